// File: rtl/reg_wb_arbiter_if.sv
// Bus bundle between the two write-back requesters, the reg_file ports and the arbiter.
// The slave modport is the arbiter's view. The master modport is the requester/reg_file side.
interface reg_wb_arbiter_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 8
);
    logic              hold;
    logic              req0_valid;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_data;
    logic              req0_ready;
    logic              req1_valid;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_data;
    logic              req1_ready;
    logic              wr_en;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic [DATA_W-1:0] rf_read_data1;
    logic [DATA_W-1:0] rf_read_data2;
    logic [ADDR_W-1:0] read_addr1;
    logic [ADDR_W-1:0] read_addr2;
    logic [DATA_W-1:0] fwd_data1;
    logic [DATA_W-1:0] fwd_data2;
    logic [CNT_W-1:0]  conflict_count;

    modport slave (
        input  hold,
        input  req0_valid, req0_addr, req0_data,
        output req0_ready,
        input  req1_valid, req1_addr, req1_data,
        output req1_ready,
        output wr_en, write_addr, write_data,
        input  rf_read_data1, rf_read_data2, read_addr1, read_addr2,
        output fwd_data1, fwd_data2,
        output conflict_count
    );

    modport master (
        output hold,
        output req0_valid, req0_addr, req0_data,
        input  req0_ready,
        output req1_valid, req1_addr, req1_data,
        input  req1_ready,
        input  wr_en, write_addr, write_data,
        output rf_read_data1, rf_read_data2, read_addr1, read_addr2,
        input  fwd_data1, fwd_data2,
        input  conflict_count
    );
endinterface

// File: rtl/reg_wb_arbiter.sv
// Round-robin arbiter for the single reg_file write port (ALU vs load write-back).
// It registers the granted write for one cycle and forwards in-flight data to both read ports.
module reg_wb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 4,
    parameter int unsigned CNT_W  = 8
) (
    input  logic            clk,
    input  logic            reset_n,
    reg_wb_arbiter_if.slave bus
);
    typedef enum logic {
        GRANT_P0 = 1'b0,
        GRANT_P1 = 1'b1
    } grant_e;

    grant_e            last_grant_q, last_grant_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] write_addr_q, write_addr_d;
    logic [DATA_W-1:0] write_data_q, write_data_d;
    logic [CNT_W-1:0]  conflict_q, conflict_d;
    logic              ready0, ready1, xfer0, xfer1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            last_grant_q <= GRANT_P1;
            wr_en_q      <= 1'b0;
            write_addr_q <= '0;
            write_data_q <= '0;
            conflict_q   <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            write_addr_q <= write_addr_d;
            write_data_q <= write_data_d;
            conflict_q   <= conflict_d;
        end
    end

    // Ready depends only on the other port's valid, so at most one transfer happens per cycle.
    always_comb begin
        ready0       = !bus.hold && (!bus.req1_valid || last_grant_q == GRANT_P1);
        ready1       = !bus.hold && (!bus.req0_valid || last_grant_q == GRANT_P0);
        xfer0        = bus.req0_valid && ready0;
        xfer1        = bus.req1_valid && ready1;
        last_grant_d = last_grant_q;
        wr_en_d      = 1'b0;
        write_addr_d = write_addr_q;
        write_data_d = write_data_q;
        conflict_d   = conflict_q;
        if (xfer0) begin
            last_grant_d = GRANT_P0;
            wr_en_d      = 1'b1;
            write_addr_d = bus.req0_addr;
            write_data_d = bus.req0_data;
        end else if (xfer1) begin
            last_grant_d = GRANT_P1;
            wr_en_d      = 1'b1;
            write_addr_d = bus.req1_addr;
            write_data_d = bus.req1_data;
        end
        if (bus.req0_valid && bus.req1_valid && !bus.hold && conflict_q != '1) begin
            conflict_d = conflict_q + CNT_W'(1);
        end
    end

    assign bus.req0_ready     = ready0;
    assign bus.req1_ready     = ready1;
    assign bus.wr_en          = wr_en_q;
    assign bus.write_addr     = write_addr_q;
    assign bus.write_data     = write_data_q;
    assign bus.conflict_count = conflict_q;

    assign bus.fwd_data1 = (wr_en_q && write_addr_q == bus.read_addr1) ? write_data_q : bus.rf_read_data1;
    assign bus.fwd_data2 = (wr_en_q && write_addr_q == bus.read_addr2) ? write_data_q : bus.rf_read_data2;
endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Directed bench for reg_wb_arbiter with a behavioural 16x32 reg_file attached to the write port.
module tb_reg_wb_arbiter;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    reg_wb_arbiter_if #(.DATA_W(32), .ADDR_W(4), .CNT_W(8)) bus ();

    reg_wb_arbiter #(.DATA_W(32), .ADDR_W(4), .CNT_W(8)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    logic [31:0] rf [16] = '{default: '0};

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus.wr_en) rf[bus.write_addr] <= bus.write_data;
    end

    assign bus.rf_read_data1 = rf[bus.read_addr1];
    assign bus.rf_read_data2 = rf[bus.read_addr2];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        bus.hold = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_addr = '0; bus.req0_data = '0;
        bus.req1_valid = 1'b0; bus.req1_addr = '0; bus.req1_data = '0;
        bus.read_addr1 = 4'd0; bus.read_addr2 = 4'd0;
        reset_n = 1'b0;
        step();
        checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%0h exp=0", bus.wr_en); end
        checks++; if (bus.write_addr !== 4'd0) begin failures++; $display("FAIL reset_write_addr got=%0h exp=0", bus.write_addr); end
        checks++; if (bus.write_data !== 32'd0) begin failures++; $display("FAIL reset_write_data got=%0h exp=0", bus.write_data); end
        checks++; if (bus.conflict_count !== 8'd0) begin failures++; $display("FAIL reset_conflict got=%0d exp=0", bus.conflict_count); end
        reset_n = 1'b1;
        step();
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b11) begin failures++; $display("FAIL idle_readys got=%b exp=11", {bus.req0_ready, bus.req1_ready}); end
        checks++; if (bus.fwd_data1 !== bus.rf_read_data1) begin failures++; $display("FAIL idle_fwd1 got=%0h exp=%0h", bus.fwd_data1, bus.rf_read_data1); end
        checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL idle_wr_en got=%0h exp=0", bus.wr_en); end
    endtask

    // From reset last_grant is 1, so the first conflict goes to port 0.
    task automatic test_alternate();
        logic [3:0] gnt;
        gnt = 4'b1010;
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd4; bus.req0_data = 32'd10;
        bus.req1_valid = 1'b1; bus.req1_addr = 4'd5; bus.req1_data = 32'd11;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({bus.req0_ready, bus.req1_ready} !== {~gnt[i], gnt[i]}) begin
                failures++; $display("FAIL alt_ready[%0d] got=%b exp=%b", i, {bus.req0_ready, bus.req1_ready}, {~gnt[i], gnt[i]});
            end
            step();
            checks++;
            if ({bus.wr_en, bus.write_addr, bus.write_data} !== {1'b1, (gnt[i] ? 4'd5 : 4'd4), (gnt[i] ? 32'd11 : 32'd10)}) begin
                failures++; $display("FAIL alt_write[%0d] got=%0h/%0h/%0h exp=1/%0h/%0h", i, bus.wr_en, bus.write_addr, bus.write_data, (gnt[i] ? 5 : 4), (gnt[i] ? 11 : 10));
            end
        end
        checks++; if (bus.conflict_count !== 8'd4) begin failures++; $display("FAIL alt_conflict got=%0d exp=4", bus.conflict_count); end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        step();
    endtask

    task automatic test_same_addr();
        bus.read_addr1 = 4'd4;
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd4; bus.req0_data = 32'd12;
        bus.req1_valid = 1'b1; bus.req1_addr = 4'd4; bus.req1_data = 32'd13;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b10) begin failures++; $display("FAIL same_first_ready got=%b exp=10", {bus.req0_ready, bus.req1_ready}); end
        step();
        checks++; if (bus.write_data !== 32'd12) begin failures++; $display("FAIL same_first_data got=%0d exp=12", bus.write_data); end
        bus.req0_valid = 1'b0;
        #1;
        checks++; if (bus.req1_ready !== 1'b1) begin failures++; $display("FAIL same_second_ready got=%0h exp=1", bus.req1_ready); end
        step();
        checks++; if (bus.rf_read_data1 !== 32'd12) begin failures++; $display("FAIL same_raw_mid got=%0d exp=12", bus.rf_read_data1); end
        checks++; if (bus.fwd_data1 !== 32'd13) begin failures++; $display("FAIL same_fwd_mid got=%0d exp=13", bus.fwd_data1); end
        bus.req1_valid = 1'b0;
        step();
        checks++; if (bus.rf_read_data1 !== 32'd13) begin failures++; $display("FAIL same_final got=%0d exp=13", bus.rf_read_data1); end
        checks++; if (bus.conflict_count !== 8'd5) begin failures++; $display("FAIL same_conflict got=%0d exp=5", bus.conflict_count); end
    endtask

    task automatic test_port0_alone();
        bus.read_addr2 = 4'd3;
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd3; bus.req0_data = 32'd5;
        #1;
        checks++; if (bus.fwd_data2 !== 32'd0) begin failures++; $display("FAIL p0_fwd_before got=%0d exp=0", bus.fwd_data2); end
        step();
        checks++; if ({bus.wr_en, bus.write_addr, bus.write_data} !== {1'b1, 4'd3, 32'd5}) begin
            failures++; $display("FAIL p0_write got=%0h/%0h/%0h exp=1/3/5", bus.wr_en, bus.write_addr, bus.write_data);
        end
        checks++; if (bus.rf_read_data2 !== 32'd0) begin failures++; $display("FAIL p0_raw_T got=%0d exp=0", bus.rf_read_data2); end
        checks++; if (bus.fwd_data2 !== 32'd5) begin failures++; $display("FAIL p0_fwd_T got=%0d exp=5", bus.fwd_data2); end
        bus.req0_valid = 1'b0;
        step();
        checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL p0_wr_en_after got=%0h exp=0", bus.wr_en); end
        checks++; if (bus.write_addr !== 4'd3) begin failures++; $display("FAIL p0_addr_hold got=%0h exp=3", bus.write_addr); end
        checks++; if (bus.rf_read_data2 !== 32'd5) begin failures++; $display("FAIL p0_raw_T1 got=%0d exp=5", bus.rf_read_data2); end
    endtask

    // last_grant is 0 after the port-0-only transfer, so release grants port 1.
    task automatic test_hold();
        bus.hold = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd6; bus.req0_data = 32'd20;
        bus.req1_valid = 1'b1; bus.req1_addr = 4'd7; bus.req1_data = 32'd21;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b00) begin failures++; $display("FAIL hold_ready[%0d] got=%b exp=00", i, {bus.req0_ready, bus.req1_ready}); end
            step();
            checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL hold_wr_en[%0d] got=%0h exp=0", i, bus.wr_en); end
        end
        checks++; if (bus.conflict_count !== 8'd5) begin failures++; $display("FAIL hold_conflict got=%0d exp=5", bus.conflict_count); end
        bus.hold = 1'b0;
        #1;
        checks++; if ({bus.req0_ready, bus.req1_ready} !== 2'b01) begin failures++; $display("FAIL release_ready got=%b exp=01", {bus.req0_ready, bus.req1_ready}); end
        step();
        checks++; if ({bus.wr_en, bus.write_addr, bus.write_data} !== {1'b1, 4'd7, 32'd21}) begin
            failures++; $display("FAIL release_write got=%0h/%0h/%0h exp=1/7/15", bus.wr_en, bus.write_addr, bus.write_data);
        end
        checks++; if (bus.conflict_count !== 8'd6) begin failures++; $display("FAIL release_conflict got=%0d exp=6", bus.conflict_count); end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        step();
    endtask

    task automatic test_reset_mid();
        bus.read_addr1 = 4'd8;
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd8; bus.req0_data = 32'd30;
        step();
        checks++; if (bus.wr_en !== 1'b1) begin failures++; $display("FAIL rmid_wr_en_pre got=%0h exp=1", bus.wr_en); end
        bus.req0_valid = 1'b0;
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (bus.wr_en !== 1'b0) begin failures++; $display("FAIL rmid_wr_en got=%0h exp=0", bus.wr_en); end
        checks++; if (bus.write_addr !== 4'd0) begin failures++; $display("FAIL rmid_addr got=%0h exp=0", bus.write_addr); end
        checks++; if (bus.conflict_count !== 8'd0) begin failures++; $display("FAIL rmid_conflict got=%0d exp=0", bus.conflict_count); end
        step();
        checks++; if (bus.rf_read_data1 !== 32'd0) begin failures++; $display("FAIL rmid_rf got=%0d exp=0", bus.rf_read_data1); end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_saturate();
        bus.req0_valid = 1'b1; bus.req0_addr = 4'd9;  bus.req0_data = 32'd40;
        bus.req1_valid = 1'b1; bus.req1_addr = 4'd10; bus.req1_data = 32'd41;
        for (int i = 0; i < 254; i++) step();
        checks++; if (bus.conflict_count !== 8'd254) begin failures++; $display("FAIL sat_254 got=%0d exp=254", bus.conflict_count); end
        step();
        checks++; if (bus.conflict_count !== 8'd255) begin failures++; $display("FAIL sat_255 got=%0d exp=255", bus.conflict_count); end
        for (int i = 0; i < 5; i++) step();
        checks++; if (bus.conflict_count !== 8'd255) begin failures++; $display("FAIL sat_hold got=%0d exp=255", bus.conflict_count); end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_alternate();
        test_same_addr();
        test_port0_alone();
        test_hold();
        test_reset_mid();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
